chip_write_sequencer: RTL and testbench

- Host-side controller that sequences the sound chip's 4-bit register bus (A0/D[3:0]/WR).
- Accepts whole-register commands: a channel select plus a 12-bit divider value, or a 3-bit output-enable control word.
- Buffers commands in a small FIFO and expands each one into the chip's address-nibble / data-nibble write cycles.
- Sits between the host/sequencing logic and the chip's bus inputs; both run on the same CLK.

---
 rtl/chip_write_sequencer_pkg.sv | 68 ++++++
 rtl/chip_write_sequencer_cmd_fifo.sv | 64 ++++++
 rtl/chip_write_sequencer.sv | 148 ++++++++++++++
 tb/tb_chip_write_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_write_sequencer_pkg.sv
// rtl/chip_write_sequencer_pkg.sv - shared constants, types and nibble helpers for the chip write sequencer
//
// Purpose: register map of the sound chip, channel and FSM encodings, and the
//          helpers that map a command plus nibble index onto bus values.
// Ports:   none (package).
package chip_write_sequencer_pkg;

   localparam logic [3:0] ADDR_T0_L   = 4'd1;
   localparam logic [3:0] ADDR_T0_H   = 4'd2;
   localparam logic [3:0] ADDR_T0_HH  = 4'd3;
   localparam logic [3:0] ADDR_T1_L   = 4'd4;
   localparam logic [3:0] ADDR_T1_H   = 4'd5;
   localparam logic [3:0] ADDR_T1_HH  = 4'd6;
   localparam logic [3:0] ADDR_TRI_L  = 4'd7;
   localparam logic [3:0] ADDR_TRI_H  = 4'd8;
   localparam logic [3:0] ADDR_TRI_HH = 4'd9;
   localparam logic [3:0] ADDR_CTRL   = 4'd15;

   localparam int CTRL_SOUT0_BIT = 0;
   localparam int CTRL_SOUT1_BIT = 1;
   localparam int CTRL_TRI_BIT   = 2;

   typedef enum logic [1:0] {
      CH_TONE0 = 2'd0,
      CH_TONE1 = 2'd1,
      CH_TRI   = 2'd2,
      CH_CTRL  = 2'd3
   } channelT;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } stateT;

   typedef struct packed {
      channelT     ch;
      logic [11:0] val;
   } cmdT;

   // Tone/triangle registers are laid out L, H, HH at consecutive addresses.
   function automatic logic [3:0] regAddr(input channelT ch, input logic [1:0] idx);
      logic [3:0] addr;
      case (ch)
         CH_TONE0: addr = ADDR_T0_L + {2'b00, idx};
         CH_TONE1: addr = ADDR_T1_L + {2'b00, idx};
         CH_TRI:   addr = ADDR_TRI_L + {2'b00, idx};
         default:  addr = ADDR_CTRL;
      endcase
      return addr;
   endfunction

   function automatic logic [3:0] dataNibble(input cmdT cmd, input logic [1:0] idx);
      logic [3:0] nib;
      if (cmd.ch == CH_CTRL) begin
         nib = {1'b0, cmd.val[CTRL_TRI_BIT], cmd.val[CTRL_SOUT1_BIT], cmd.val[CTRL_SOUT0_BIT]};
      end else begin
         case (idx)
            2'd0:    nib = cmd.val[3:0];
            2'd1:    nib = cmd.val[7:4];
            default: nib = cmd.val[11:8];
         endcase
      end
      return nib;
   endfunction

endpackage

// File: rtl/chip_write_sequencer_cmd_fifo.sv
// rtl/chip_write_sequencer_cmd_fifo.sv - command FIFO holding {channel, value} entries
//
// Purpose: synchronous FIFO of whole-register commands, no bypass path.
// Ports:   clk, rst       clock and asynchronous active-high reset
//          push, pushData write request and entry (refused while full)
//          pop            read request (ignored while empty)
//          full, empty    occupancy flags from the registered count
//          head           entry at the read pointer
//          count          number of stored entries
module chip_write_sequencer_cmd_fifo
   import chip_write_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              push,
   input  cmdT                               pushData,
   input  logic                              pop,
   output logic                              full,
   output logic                              empty,
   output cmdT                               head,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   cmdT           mem [FIFO_DEPTH];
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic          pushOk;
   logic          popOk;

   assign full   = (count == CW'(FIFO_DEPTH));
   assign empty  = (count == '0);
   assign pushOk = push && !full;
   assign popOk  = pop && !empty;
   assign head   = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (pushOk) begin
         mem[wrPtr] <= pushData;
      end
   end

   // Depth is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (pushOk) wrPtr <= wrPtr + PW'(1);
         if (popOk)  rdPtr <= rdPtr + PW'(1);
         case ({pushOk, popOk})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/chip_write_sequencer.sv
// rtl/chip_write_sequencer.sv - expands queued register commands into A0/D/WR nibble cycles
//
// Purpose: buffers host commands and drives the sound chip's 4-bit register bus.
// Ports:   CLK, RST             clock and asynchronous active-high reset
//          CMD_VALID/CMD_READY  command handshake (READY = FIFO not full)
//          CMD_CH, CMD_VAL      channel select and 12-bit divider / control word
//          A0, D, WR            registered chip bus (address/data nibble, strobe)
//          BUSY                 FSM active or commands queued
//          DONE                 one-cycle pulse after a command's last data nibble
module chip_write_sequencer
   import chip_write_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [1:0]  CMD_CH,
   input  logic [11:0] CMD_VAL,
   output logic        A0,
   output logic [3:0]  D,
   output logic        WR,
   output logic        BUSY,
   output logic        DONE
);

   localparam logic [1:0] GAP_LOAD = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

   stateT      state, nextState;
   cmdT        work, nextWork;
   logic [1:0] idx, nextIdx;
   logic [1:0] gapCnt, nextGapCnt;
   logic       nextA0, nextWr, nextDone;
   logic [3:0] nextD;
   logic       startCmd, advance, lastNibble;

   logic                            fifoPop, fifoFull, fifoEmpty;
   cmdT                             fifoHead;
   logic [$clog2(FIFO_DEPTH+1)-1:0] fifoCount;

   chip_write_sequencer_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) cmdFifo (
      .clk      (CLK),
      .rst      (RST),
      .push     (CMD_VALID),
      .pushData (cmdT'({CMD_CH, CMD_VAL})),
      .pop      (fifoPop),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .head     (fifoHead),
      .count    (fifoCount)
   );

   assign CMD_READY  = !fifoFull;
   assign BUSY       = (state != ST_IDLE) || (fifoCount != '0);
   assign lastNibble = (work.ch == CH_CTRL) || (idx == 2'd2);

   // Bus outputs are computed for the state being entered and registered,
   // so the first ADDR cycle appears on the same edge that pops the FIFO.
   always_comb begin
      nextState  = state;
      nextWork   = work;
      nextIdx    = idx;
      nextGapCnt = gapCnt;
      nextA0     = 1'b0;
      nextD      = 4'd0;
      nextWr     = 1'b0;
      nextDone   = 1'b0;
      fifoPop    = 1'b0;
      startCmd   = 1'b0;
      advance    = 1'b0;

      case (state)
         ST_IDLE: begin
            startCmd = !fifoEmpty;
         end
         ST_ADDR: begin
            nextState = ST_DATA;
            nextA0    = 1'b1;
            nextWr    = 1'b1;
            nextD     = dataNibble(work, idx);
         end
         ST_DATA: begin
            nextDone = lastNibble;
            if (GAP_CYCLES != 0) begin
               nextState  = ST_GAP;
               nextGapCnt = GAP_LOAD;
            end else if (!lastNibble) begin
               advance = 1'b1;
            end else if (!fifoEmpty) begin
               // Without gaps the next queued command follows directly.
               startCmd = 1'b1;
            end else begin
               nextState = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gapCnt != 2'd0) begin
               nextGapCnt = gapCnt - 2'd1;
            end else if (lastNibble) begin
               nextState = ST_IDLE;
            end else begin
               advance = 1'b1;
            end
         end
         default: nextState = ST_IDLE;
      endcase

      if (startCmd) begin
         fifoPop   = 1'b1;
         nextWork  = fifoHead;
         nextIdx   = 2'd0;
         nextState = ST_ADDR;
         nextWr    = 1'b1;
         nextD     = regAddr(fifoHead.ch, 2'd0);
      end
      if (advance) begin
         nextIdx   = idx + 2'd1;
         nextState = ST_ADDR;
         nextWr    = 1'b1;
         nextD     = regAddr(work.ch, idx + 2'd1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= ST_IDLE;
         work   <= '0;
         idx    <= 2'd0;
         gapCnt <= 2'd0;
         A0     <= 1'b0;
         D      <= 4'd0;
         WR     <= 1'b0;
         DONE   <= 1'b0;
      end else begin
         state  <= nextState;
         work   <= nextWork;
         idx    <= nextIdx;
         gapCnt <= nextGapCnt;
         A0     <= nextA0;
         D      <= nextD;
         WR     <= nextWr;
         DONE   <= nextDone;
      end
   end

endmodule

// File: tb/tb_chip_write_sequencer.sv
// tb/tb_chip_write_sequencer.sv - self-checking bench for chip_write_sequencer
module tb_chip_write_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        v1, r1, a01, wr1, busy1, done1;
   logic [1:0]  ch1;
   logic [11:0] val1;
   logic [3:0]  d1;
   logic        v0, r0, a00, wr0, busy0, done0;
   logic [1:0]  ch0;
   logic [11:0] val0;
   logic [3:0]  d0;

   int compared   = 0;
   int mismatched = 0;

   logic [4:0] obs1[$], obs0[$], exp1[$], exp0[$];
   int doneCnt1 = 0, doneCnt0 = 0;

   chip_write_sequencer #(.FIFO_DEPTH(4), .GAP_CYCLES(1)) dutGap1 (
      .CLK(clk), .RST(rst), .CMD_VALID(v1), .CMD_READY(r1), .CMD_CH(ch1), .CMD_VAL(val1),
      .A0(a01), .D(d1), .WR(wr1), .BUSY(busy1), .DONE(done1));

   chip_write_sequencer #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) dutGap0 (
      .CLK(clk), .RST(rst), .CMD_VALID(v0), .CMD_READY(r0), .CMD_CH(ch0), .CMD_VAL(val0),
      .A0(a00), .D(d0), .WR(wr0), .BUSY(busy0), .DONE(done0));

   always @(negedge clk) begin
      if (wr1 === 1'b1) obs1.push_back({a01, d1});
      if (done1 === 1'b1) doneCnt1++;
      if (wr0 === 1'b1) obs0.push_back({a00, d0});
      if (done0 === 1'b1) doneCnt0++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: each command becomes (address, data) write pairs.
   function automatic void modelCmd(input bit sel, input logic [1:0] ch, input logic [11:0] val);
      logic [4:0] w[$];
      if (ch == 2'd3) begin
         w.push_back({1'b0, 4'd15});
         w.push_back({2'b10, val[2:0]});
      end else begin
         for (int i = 0; i < 3; i++) begin
            w.push_back({1'b0, 4'(1 + 3 * ch + i)});
            w.push_back({1'b1, val[4*i +: 4]});
         end
      end
      foreach (w[j]) begin
         if (sel) exp1.push_back(w[j]);
         else     exp0.push_back(w[j]);
      end
   endfunction

   task automatic pushCmd(input bit sel, input logic [1:0] ch, input logic [11:0] val, output int waited);
      waited = 0;
      if (sel) begin v1 = 1'b1; ch1 = ch; val1 = val; end
      else     begin v0 = 1'b1; ch0 = ch; val0 = val; end
      while (((sel ? r1 : r0) !== 1'b1) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 100) check("push_ready_timeout", sel ? r1 : r0, 1);
      @(negedge clk);
      if (sel) v1 = 1'b0;
      else     v0 = 1'b0;
      modelCmd(sel, ch, val);
   endtask

   task automatic waitIdle(input bit sel);
      int n = 0;
      while (((sel ? busy1 : busy0) !== 1'b0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check(sel ? "idle_g1" : "idle_g0", sel ? busy1 : busy0, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic clearStreams();
      @(posedge clk);
      obs1.delete(); obs0.delete(); exp1.delete(); exp0.delete();
      doneCnt1 = 0; doneCnt0 = 0;
      @(negedge clk);
   endtask

   task automatic compareStreams(input bit sel, input int nCmds, input string tag);
      logic [4:0] o[$], e[$];
      int dc;
      if (sel) begin o = obs1; e = exp1; dc = doneCnt1; end
      else     begin o = obs0; e = exp0; dc = doneCnt0; end
      check({tag, "_len"}, o.size(), e.size());
      for (int i = 0; i < e.size() && i < o.size(); i++)
         check($sformatf("%s_w%0d", tag, i), o[i], e[i]);
      check({tag, "_done"}, dc, nCmds);
   endtask

   // bus entry = {A0, WR, D}: ADDR = 6'h1x, DATA = 6'h3x, idle = 6'h00
   typedef struct packed {
      logic [1:0]       ch;
      logic [11:0]      val;
      logic [3:0]       n;
      logic [0:8][5:0]  bus;
   } vecT;
   vecT vecs[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      logic [11:0] tv [2];
      logic [1:0]  fch [6];
      logic [11:0] fval [6];

      vecs[0] = '{ch:2'd0, val:12'hA5C, n:4'd9, bus:{6'h11,6'h3C,6'h00,6'h12,6'h35,6'h00,6'h13,6'h3A,6'h00}};
      vecs[1] = '{ch:2'd3, val:12'hFFD, n:4'd3, bus:{6'h1F,6'h35,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00}};
      vecs[2] = '{ch:2'd2, val:12'h123, n:4'd9, bus:{6'h17,6'h33,6'h00,6'h18,6'h32,6'h00,6'h19,6'h31,6'h00}};
      vecs[3] = '{ch:2'd1, val:12'hF0E, n:4'd9, bus:{6'h14,6'h3E,6'h00,6'h15,6'h30,6'h00,6'h16,6'h3F,6'h00}};
      vecs[4] = '{ch:2'd3, val:12'h002, n:4'd3, bus:{6'h1F,6'h32,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00}};
      vecs[5] = '{ch:2'd0, val:12'h000, n:4'd9, bus:{6'h11,6'h30,6'h00,6'h12,6'h30,6'h00,6'h13,6'h30,6'h00}};

      // Reset with VALID held high
      rst = 1'b1;
      v1 = 1'b1; ch1 = 2'd3; val1 = 12'h001;
      v0 = 1'b1; ch0 = 2'd0; val0 = 12'h123;
      repeat (3) @(negedge clk);
      check("rst_a0", a01, 0);
      check("rst_d", d1, 0);
      check("rst_wr", wr1, 0);
      check("rst_done", done1, 0);
      check("rst_busy", busy1, 0);
      check("rst_ready", r1, 1);
      check("rst_busy_g0", busy0, 0);
      check("rst_ready_g0", r0, 1);
      v1 = 1'b0; v0 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_busy", busy1, 0);
      check("post_rst_busy_g0", busy0, 0);

      // Table-driven single commands on the GAP_CYCLES=1 instance
      clearStreams();
      foreach (vecs[t]) begin
         pushCmd(1'b1, vecs[t].ch, vecs[t].val, w);
         for (int i = 0; i < int'(vecs[t].n); i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_bus%0d", t, i), {a01, wr1, d1}, vecs[t].bus[i]);
            check($sformatf("vec%0d_done%0d", t, i), done1, (i == int'(vecs[t].n) - 1));
         end
         @(negedge clk);
         check($sformatf("vec%0d_busy_after", t), busy1, 0);
         check($sformatf("vec%0d_done_after", t), done1, 0);
      end
      compareStreams(1'b1, 6, "table");

      // FIFO full while the sequencer is busy with a first command
      clearStreams();
      fch  = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd3, 2'd2};
      fval = '{12'h9A1, 12'h456, 12'hC3B, 12'h789, 12'h006, 12'hDEF};
      pushCmd(1'b1, fch[0], fval[0], w);
      for (int k = 1; k < 6; k++) begin
         pushCmd(1'b1, fch[k], fval[k], w);
         if (k < 5) check($sformatf("fifo_wait%0d", k), w, 0);
         else       check("fifo5_stalled", (w > 0), 1);
         if (k == 4) check("fifo_full_ready", r1, 0);
      end
      waitIdle(1'b1);
      compareStreams(1'b1, 6, "fifo");

      // GAP_CYCLES=0: two tone1 commands back to back
      clearStreams();
      tv = '{12'h321, 12'h9B7};
      pushCmd(1'b0, 2'd1, tv[0], w);
      pushCmd(1'b0, 2'd1, tv[1], w);
      for (int i = 1; i <= 13; i++) begin
         logic [5:0] e;
         int k;
         if (i > 1) @(negedge clk);
         if (i <= 12) begin
            k = (i - 1) / 2;
            if (i % 2 == 0) e = {2'b11, tv[k/3][4*(k%3) +: 4]};
            else            e = {2'b01, 4'(4 + k % 3)};
         end else begin
            e = 6'h00;
         end
         check($sformatf("gap0_bus%0d", i), {a00, wr0, d0}, e);
         check($sformatf("gap0_done%0d", i), done0, (i == 7 || i == 13));
      end
      waitIdle(1'b0);
      compareStreams(1'b0, 2, "gap0");

      // Randomized commands against the reference model, both instances
      for (int s = 1; s >= 0; s--) begin
         clearStreams();
         for (int n = 0; n < 30; n++) begin
            pushCmd(s[0], 2'($urandom_range(0, 3)), 12'($urandom), w);
            repeat ($urandom_range(0, 4)) @(negedge clk);
         end
         waitIdle(s[0]);
         compareStreams(s[0], 30, s ? "rand_g1" : "rand_g0");
      end

      // Reset during the H data cycle with a second command queued
      clearStreams();
      pushCmd(1'b1, 2'd0, 12'h7E4, w);
      pushCmd(1'b1, 2'd2, 12'h111, w);
      repeat (4) @(negedge clk);
      check("midrst_h_data", {a01, wr1, d1}, 6'h3E);
      #1 rst = 1'b1;
      #1;
      check("midrst_wr", wr1, 0);
      check("midrst_a0", a01, 0);
      check("midrst_d", d1, 0);
      check("midrst_busy", busy1, 0);
      check("midrst_ready", r1, 1);
      @(negedge clk);
      rst = 1'b0;
      begin
         int writes = 0;
         repeat (20) begin
            @(negedge clk);
            if (wr1 !== 1'b0) writes++;
         end
         check("midrst_no_writes", writes, 0);
         check("midrst_busy_after", busy1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
